// File: rtl/fetch_stage_pkg.sv
// Shared types for the RV32I fetch stage: IF/ID payload, fetch FSM states, PC step.
package rv32i_types;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_reg_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  // Instruction addresses are word aligned; the low two bits are discarded.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-cache read/response bus between the fetch stage (master) and the L1 I-cache (slave).
interface fetch_stage_if;

  logic        imem_read;
  logic [31:0] imem_address;
  logic [31:0] imem_rdata;
  logic        imem_resp;

  modport master (
    output imem_read,
    output imem_address,
    input  imem_rdata,
    input  imem_resp
  );

  modport slave (
    input  imem_read,
    input  imem_address,
    output imem_rdata,
    output imem_resp
  );

endinterface

// File: rtl/fetch_stage_fsm.sv
// Fetch control FSM: tracks the outstanding I-cache request and decodes the
// load / PC-update strobes consumed by the datapath in fetch_stage.
module fetch_fsm
  import rv32i_types::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         resp_i,
  input  logic         redirect_i,
  input  logic         stall_i,
  output fetch_state_t state_o,
  output logic         imem_read_o,
  output logic         load_o,
  output logic         valid_o,
  output logic         use_hold_o,
  output logic         capture_hold_o,
  output logic         pc_redirect_o,
  output logic         req_redirect_o,
  output logic         advance_o,
  output logic         req_from_pc_o
);

  fetch_state_t state_q;
  fetch_state_t state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    imem_read_o    = 1'b0;
    load_o         = 1'b0;
    valid_o        = 1'b0;
    use_hold_o     = 1'b0;
    capture_hold_o = 1'b0;
    pc_redirect_o  = 1'b0;
    req_redirect_o = 1'b0;
    advance_o      = 1'b0;
    req_from_pc_o  = 1'b0;

    unique case (state_q)
      FETCH: begin
        imem_read_o = 1'b1;
        if (resp_i) begin
          if (redirect_i) begin
            load_o         = 1'b1;
            pc_redirect_o  = 1'b1;
            req_redirect_o = 1'b1;
          end else if (!stall_i) begin
            load_o    = 1'b1;
            valid_o   = 1'b1;
            advance_o = 1'b1;
          end else begin
            capture_hold_o = 1'b1;
            state_d        = HOLD;
          end
        end else if (redirect_i) begin
          // The request in flight belongs to the squashed path; drain it in FLUSH.
          load_o        = 1'b1;
          pc_redirect_o = 1'b1;
          state_d       = FLUSH;
        end
      end

      HOLD: begin
        if (redirect_i) begin
          load_o         = 1'b1;
          pc_redirect_o  = 1'b1;
          req_redirect_o = 1'b1;
          state_d        = FETCH;
        end else if (!stall_i) begin
          load_o     = 1'b1;
          valid_o    = 1'b1;
          use_hold_o = 1'b1;
          advance_o  = 1'b1;
          state_d    = FETCH;
        end
      end

      FLUSH: begin
        imem_read_o = 1'b1;
        if (redirect_i) begin
          load_o        = 1'b1;
          pc_redirect_o = 1'b1;
        end
        if (resp_i) begin
          req_from_pc_o  = 1'b1;
          req_redirect_o = redirect_i;
          state_d        = FETCH;
        end
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  assign state_o = state_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, drives the I-cache bus and the IF/ID load.
// Optional performance counters are enabled with `define FETCH_PERF_EN.
module fetch_stage
  import rv32i_types::*;
#(
  parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [31:0]          redirect_pc,
  fetch_stage_if.master        imem,
  output logic                 if_id_load,
  output if_id_reg_t           if_id_o,
  output logic [31:0]          perf_fetched,
  output logic [31:0]          perf_stall
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] target_pc;
  logic [31:0] next_seq_pc;

  fetch_state_t state;
  logic fsm_read;
  logic fsm_load;
  logic fsm_valid;
  logic use_hold;
  logic capture_hold;
  logic pc_redirect;
  logic req_redirect;
  logic advance;
  logic req_from_pc;

  if_id_reg_t payload;

  fetch_fsm u_fsm (
    .clk            (clk),
    .rst            (rst),
    .resp_i         (imem.imem_resp),
    .redirect_i     (redirect),
    .stall_i        (stall),
    .state_o        (state),
    .imem_read_o    (fsm_read),
    .load_o         (fsm_load),
    .valid_o        (fsm_valid),
    .use_hold_o     (use_hold),
    .capture_hold_o (capture_hold),
    .pc_redirect_o  (pc_redirect),
    .req_redirect_o (req_redirect),
    .advance_o      (advance),
    .req_from_pc_o  (req_from_pc)
  );

  assign target_pc   = align_word(redirect_pc);
  assign next_seq_pc = req_addr_q + PC_STEP;

  always_comb begin
    pc_d = pc_q;
    if (pc_redirect) begin
      pc_d = target_pc;
    end else if (advance) begin
      pc_d = next_seq_pc;
    end
  end

  // req_addr only moves when the current request has completed (or none is pending).
  always_comb begin
    req_addr_d = req_addr_q;
    if (req_redirect) begin
      req_addr_d = target_pc;
    end else if (req_from_pc) begin
      req_addr_d = pc_q;
    end else if (advance) begin
      req_addr_d = next_seq_pc;
    end
  end

  assign hold_instr_d = capture_hold ? imem.imem_rdata : hold_instr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      req_addr_q   <= RESET_PC;
      hold_instr_q <= '0;
    end else begin
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      hold_instr_q <= hold_instr_d;
    end
  end

  always_comb begin
    payload = '0;
    if (fsm_valid) begin
      payload.valid = 1'b1;
      payload.pc    = req_addr_q;
      payload.instr = use_hold ? hold_instr_q : imem.imem_rdata;
    end
  end

  assign imem.imem_read    = fsm_read & ~rst;
  assign imem.imem_address = req_addr_q;
  assign if_id_load        = fsm_load & ~rst;
  assign if_id_o           = (fsm_load && !rst) ? payload : '0;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic        fetched_inc;
  logic        stall_inc;

  assign fetched_inc = if_id_load & if_id_o.valid;
  assign stall_inc   = (state == HOLD) & stall;

  // Both counters saturate rather than wrap.
  assign perf_fetched_d = (fetched_inc && perf_fetched_q != 32'hFFFF_FFFF)
                          ? perf_fetched_q + 32'd1 : perf_fetched_q;
  assign perf_stall_d   = (stall_inc && perf_stall_q != 32'hFFFF_FFFF)
                          ? perf_stall_q + 32'd1 : perf_stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`else
  logic unused_state;
  assign unused_state = ^state;
  assign perf_fetched = '0;
  assign perf_stall   = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus pushes expected addresses/loads, a negedge monitor checks them.
module tb_fetch_stage;
  import rv32i_types::*;

  localparam logic [31:0] RST_PC = 32'h4000_0000;
`ifdef FETCH_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_id_load;
  if_id_reg_t  if_id_o;
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;

  fetch_stage_if bus ();

  int checks = 0;
  int errors = 0;

  if_id_reg_t  exp_load_q[$];
  logic [31:0] exp_addr_q[$];

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem         (bus.master),
    .if_id_load   (if_id_load),
    .if_id_o      (if_id_o),
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic want_addr(input logic [31:0] a);
    exp_addr_q.push_back(a);
  endtask

  task automatic want_load(input logic v, input logic [31:0] pc, input logic [31:0] instr);
    if_id_reg_t e;
    e.valid = v;
    e.pc    = pc;
    e.instr = instr;
    exp_load_q.push_back(e);
  endtask

  // One clock of stimulus; inputs return to idle afterwards.
  task automatic step(input logic resp, input logic [31:0] rdata, input logic st,
                      input logic rd, input logic [31:0] rpc);
    bus.imem_resp  = resp;
    bus.imem_rdata = rdata;
    stall          = st;
    redirect       = rd;
    redirect_pc    = rpc;
    @(posedge clk);
    #1;
    bus.imem_resp  = 1'b0;
    bus.imem_rdata = '0;
    stall          = 1'b0;
    redirect       = 1'b0;
    redirect_pc    = '0;
  endtask

  // Monitor: every cache response and every IF/ID load is matched against the queues.
  if_id_reg_t  mon_load;
  logic [31:0] mon_addr;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.imem_resp && !bus.imem_read) begin
        checks++;
        errors++;
        $display("FAIL resp_without_read: imem_read=%b, required 1", bus.imem_read);
      end
      if (bus.imem_resp && bus.imem_read) begin
        checks++;
        if (exp_addr_q.size() == 0) begin
          errors++;
          $display("FAIL req_addr: response at %h, no request required", bus.imem_address);
        end else begin
          mon_addr = exp_addr_q.pop_front();
          $display("req  addr=%h rdata=%h", bus.imem_address, bus.imem_rdata);
          if (bus.imem_address !== mon_addr) begin
            errors++;
            $display("FAIL req_addr: got %h, required %h", bus.imem_address, mon_addr);
          end
        end
      end
      if (if_id_load) begin
        checks++;
        if (exp_load_q.size() == 0) begin
          errors++;
          $display("FAIL if_id_load: load of %h, no load required", if_id_o);
        end else begin
          mon_load = exp_load_q.pop_front();
          $display("load valid=%b pc=%h instr=%h", if_id_o.valid, if_id_o.pc, if_id_o.instr);
          if (if_id_o !== mon_load) begin
            errors++;
            $display("FAIL if_id_payload: got %h, required %h", if_id_o, mon_load);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.imem_resp  = 1'b0;
    bus.imem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_imem_read", 65'(bus.imem_read), 65'd0);
    check("rst_if_id_load", 65'(if_id_load), 65'd0);
    check("rst_if_id_o", if_id_o, 65'd0);
    check("rst_perf_fetched", 65'(perf_fetched), 65'd0);
    rst = 1'b0;
    #1;
    check("first_req_read", 65'(bus.imem_read), 65'd1);
    check("first_req_addr", 65'(bus.imem_address), 65'(RST_PC));

    // 1: back-to-back delivery
    want_addr(32'h4000_0000); want_load(1'b1, 32'h4000_0000, 32'h0010_0093);
    step(1'b1, 32'h0010_0093, 1'b0, 1'b0, 32'h0);
    want_addr(32'h4000_0004); want_load(1'b1, 32'h4000_0004, 32'h0020_0113);
    step(1'b1, 32'h0020_0113, 1'b0, 1'b0, 32'h0);
    want_addr(32'h4000_0008); want_load(1'b1, 32'h4000_0008, 32'h0030_0193);
    step(1'b1, 32'h0030_0193, 1'b0, 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    // 2: stall on response, hold for three stall cycles, then deliver
    want_addr(32'h4000_000C);
    step(1'b1, 32'h0000_0013, 1'b1, 1'b0, 32'h0);
    check("hold_read_low", 65'(bus.imem_read), 65'd0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    want_load(1'b1, 32'h4000_000C, 32'h0000_0013);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("after_hold_addr", 65'(bus.imem_address), 65'(32'h4000_0010));
    want_addr(32'h4000_0010); want_load(1'b1, 32'h4000_0010, 32'h0040_0213);
    step(1'b1, 32'h0040_0213, 1'b0, 1'b0, 32'h0);

    // 3: redirect with a request pending; stale response dropped
    want_load(1'b0, 32'h0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'h4000_0100);
    check("flush_read", 65'(bus.imem_read), 65'd1);
    check("flush_stale_addr", 65'(bus.imem_address), 65'(32'h4000_0014));
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    want_addr(32'h4000_0014);
    step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    want_addr(32'h4000_0100); want_load(1'b1, 32'h4000_0100, 32'h0050_0293);
    step(1'b1, 32'h0050_0293, 1'b0, 1'b0, 32'h0);

    // 4: redirect coincident with response, misaligned target
    want_addr(32'h4000_0104); want_load(1'b0, 32'h0, 32'h0);
    step(1'b1, 32'hBAD0_0001, 1'b0, 1'b1, 32'h4000_0203);
    want_addr(32'h4000_0200); want_load(1'b1, 32'h4000_0200, 32'h0060_0313);
    step(1'b1, 32'h0060_0313, 1'b0, 1'b0, 32'h0);

    // 5: redirect while stalled in HOLD
    want_addr(32'h4000_0204);
    step(1'b1, 32'h0070_0393, 1'b1, 1'b0, 32'h0);
    want_load(1'b0, 32'h0, 32'h0);
    step(1'b0, 32'h0, 1'b1, 1'b1, 32'h4000_0300);
    want_addr(32'h4000_0300); want_load(1'b1, 32'h4000_0300, 32'h0080_0413);
    step(1'b1, 32'h0080_0413, 1'b0, 1'b0, 32'h0);

    // second redirect during FLUSH replaces the target
    want_load(1'b0, 32'h0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'h4000_0400);
    want_load(1'b0, 32'h0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'h4000_0500);
    want_addr(32'h4000_0304);
    step(1'b1, 32'hDEAD_0002, 1'b0, 1'b0, 32'h0);
    want_addr(32'h4000_0500); want_load(1'b1, 32'h4000_0500, 32'h0090_0493);
    step(1'b1, 32'h0090_0493, 1'b0, 1'b0, 32'h0);

    // PC wrap at the top of the address space
    want_addr(32'h4000_0504); want_load(1'b0, 32'h0, 32'h0);
    step(1'b1, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    want_addr(32'hFFFF_FFFC); want_load(1'b1, 32'hFFFF_FFFC, 32'h00A0_0513);
    step(1'b1, 32'h00A0_0513, 1'b0, 1'b0, 32'h0);
    want_addr(32'h0000_0000); want_load(1'b1, 32'h0000_0000, 32'h00B0_0593);
    step(1'b1, 32'h00B0_0593, 1'b0, 1'b0, 32'h0);

    check("perf_fetched", 65'(perf_fetched), PERF_ON ? 65'd11 : 65'd0);
    check("perf_stall", 65'(perf_stall), PERF_ON ? 65'd3 : 65'd0);

    // 6: reset asserted mid-FLUSH
    want_load(1'b0, 32'h0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'h4000_0600);
    rst = 1'b1;
    #1;
    check("midrst_imem_read", 65'(bus.imem_read), 65'd0);
    check("midrst_if_id_load", 65'(if_id_load), 65'd0);
    check("midrst_if_id_o", if_id_o, 65'd0);
    check("midrst_perf_fetched", 65'(perf_fetched), 65'd0);
    check("midrst_perf_stall", 65'(perf_stall), 65'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rerst_addr", 65'(bus.imem_address), 65'(RST_PC));
    check("rerst_read", 65'(bus.imem_read), 65'd1);
    want_addr(RST_PC); want_load(1'b1, RST_PC, 32'h00C0_0613);
    step(1'b1, 32'h00C0_0613, 1'b0, 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    check("addr_queue_drained", 65'(exp_addr_q.size()), 65'd0);
    check("load_queue_drained", 65'(exp_load_q.size()), 65'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
